ram_arbiter: RTL and testbench

Two-port arbiter that shares the single-port data RAM between two bus masters: port 0 is the processor memory port, port 1 is a loader/debug DMA. Each access is a request/acknowledge transaction: round-robin grant, one RAM cycle, one acknowledge cycle. The arbiter sits between the masters and `RAM`, driving the RAM word address (byte address bits [15:2]), write enable and write data. RAM read is combinational and RAM write is synchronous.

---
 rtl/mem_pkg.sv | 21 ++
 rtl/rr_select2.sv | 20 ++
 rtl/ram_arbiter.sv | 127 ++++++++++++
 tb/tb_ram_arbiter.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared definitions for the data-RAM arbiter: FSM encoding, default widths
// and the address-range rule that decides whether an access may touch the RAM.
package mem_pkg;

  localparam int ADDR_WIDTH = 14;
  localparam int DATA_WIDTH = 32;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } arb_state_t;

  // Reject anything outside the RAM window or not word-aligned.
  function automatic logic addr_reject(input logic [31:0] addr, input int unsigned aw);
    logic [31:0] high_bits;
    high_bits = addr >> (aw + 2);
    return (high_bits != 32'd0) || (addr[1:0] != 2'b00);
  endfunction

endpackage

// File: rtl/rr_select2.sv
// Two-way round-robin pick: a lone requester wins, a tie goes to the
// requester that did not win last time.
module rr_select2 (
  input  logic req0,
  input  logic req1,
  input  logic last,
  output logic grant,
  output logic valid
);

  always_comb begin
    valid = req0 | req1;
    if (req0 && req1) begin
      grant = ~last;
    end else begin
      grant = req1;
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// Shares the single-port data RAM between the CPU port (M0) and the loader
// port (M1): grant, one RAM cycle, one acknowledge cycle.
module ram_arbiter
  import mem_pkg::*;
#(
  parameter int AddrWidth = ADDR_WIDTH,
  parameter int DataWidth = DATA_WIDTH
) (
  input  logic                 Clock,
  input  logic                 Reset,
  input  logic                 M0_Req,
  input  logic                 M0_Write,
  input  logic [31:0]          M0_Address,
  input  logic [DataWidth-1:0] M0_WriteData,
  output logic                 M0_Ack,
  output logic                 M0_Err,
  output logic [DataWidth-1:0] M0_ReadData,
  input  logic                 M1_Req,
  input  logic                 M1_Write,
  input  logic [31:0]          M1_Address,
  input  logic [DataWidth-1:0] M1_WriteData,
  output logic                 M1_Ack,
  output logic                 M1_Err,
  output logic [DataWidth-1:0] M1_ReadData,
  output logic [AddrWidth-1:0] Ram_Address,
  output logic                 Ram_MemWrite,
  output logic [DataWidth-1:0] Ram_WriteData,
  input  logic [DataWidth-1:0] Ram_ReadData
);

  arb_state_t           state_reg;
  logic                 last_reg;
  logic                 port_reg;
  logic                 write_reg;
  logic                 reject_reg;
  logic [AddrWidth-1:0] ram_addr_reg;
  logic [DataWidth-1:0] ram_wdata_reg;

  logic                 pick;
  logic                 pick_valid;

  logic                 req_write [2];
  logic [31:0]          req_addr  [2];
  logic [DataWidth-1:0] req_wdata [2];

  assign req_write[0] = M0_Write;
  assign req_write[1] = M1_Write;
  assign req_addr[0]  = M0_Address;
  assign req_addr[1]  = M1_Address;
  assign req_wdata[0] = M0_WriteData;
  assign req_wdata[1] = M1_WriteData;

  rr_select2 u_select (
    .req0  (M0_Req),
    .req1  (M1_Req),
    .last  (last_reg),
    .grant (pick),
    .valid (pick_valid)
  );

  // Command latch and RAM-side registers are only loaded at grant, so the
  // RAM sees a stable address/data for the whole ACCESS cycle.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_reg     <= ST_IDLE;
      last_reg      <= 1'b1;
      port_reg      <= 1'b0;
      write_reg     <= 1'b0;
      reject_reg    <= 1'b0;
      ram_addr_reg  <= '0;
      ram_wdata_reg <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (pick_valid) begin
            port_reg      <= pick;
            last_reg      <= pick;
            write_reg     <= req_write[pick];
            reject_reg    <= addr_reject(req_addr[pick], AddrWidth);
            ram_addr_reg  <= req_addr[pick][AddrWidth+1:2];
            ram_wdata_reg <= req_wdata[pick];
            state_reg     <= ST_ACCESS;
          end
        end
        ST_ACCESS: state_reg <= ST_RESP;
        ST_RESP:   state_reg <= ST_IDLE;
        default:   state_reg <= ST_IDLE;
      endcase
    end
  end

  // Decoded from state so an asynchronous reset kills the strobe at once.
  assign Ram_MemWrite  = (state_reg == ST_ACCESS) && write_reg && !reject_reg;
  assign Ram_Address   = ram_addr_reg;
  assign Ram_WriteData = ram_wdata_reg;

  for (genvar gi = 0; gi < 2; gi++) begin : g_port
    logic                 ack_reg;
    logic                 err_reg;
    logic [DataWidth-1:0] rdata_reg;
    logic                 mine;

    assign mine = (state_reg == ST_ACCESS) && (port_reg == 1'(gi));

    always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
        ack_reg   <= 1'b0;
        err_reg   <= 1'b0;
        rdata_reg <= '0;
      end else begin
        ack_reg <= mine;
        err_reg <= mine && reject_reg;
        if (mine && !write_reg) begin
          rdata_reg <= reject_reg ? '0 : Ram_ReadData;
        end
      end
    end
  end

  assign M0_Ack      = g_port[0].ack_reg;
  assign M0_Err      = g_port[0].err_reg;
  assign M0_ReadData = g_port[0].rdata_reg;
  assign M1_Ack      = g_port[1].ack_reg;
  assign M1_Err      = g_port[1].err_reg;
  assign M1_ReadData = g_port[1].rdata_reg;

endmodule

// File: tb/tb_ram_arbiter.sv
// Scoreboard bench for ram_arbiter with a behavioural single-port RAM attached.
module tb_ram_arbiter;

  logic        Clock = 1'b0;
  logic        Reset;
  logic        M0_Req, M0_Write, M1_Req, M1_Write;
  logic [31:0] M0_Address, M1_Address, M0_WriteData, M1_WriteData;
  logic        M0_Ack, M0_Err, M1_Ack, M1_Err;
  logic [31:0] M0_ReadData, M1_ReadData;
  logic [13:0] Ram_Address;
  logic        Ram_MemWrite;
  logic [31:0] Ram_WriteData, Ram_ReadData;

  logic [31:0] ram [0:16383];
  logic [31:0] model [int];

  typedef struct {
    bit          w;
    bit          err;
    logic [31:0] rd;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int   ack_port[$];
  int   ack_cyc[$];
  int   n_checks = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   wr_pulses = 0;
  logic [13:0] wr_addr_seen = '0;

  always #5 Clock = ~Clock;

  ram_arbiter dut (
    .Clock(Clock), .Reset(Reset),
    .M0_Req(M0_Req), .M0_Write(M0_Write), .M0_Address(M0_Address), .M0_WriteData(M0_WriteData),
    .M0_Ack(M0_Ack), .M0_Err(M0_Err), .M0_ReadData(M0_ReadData),
    .M1_Req(M1_Req), .M1_Write(M1_Write), .M1_Address(M1_Address), .M1_WriteData(M1_WriteData),
    .M1_Ack(M1_Ack), .M1_Err(M1_Err), .M1_ReadData(M1_ReadData),
    .Ram_Address(Ram_Address), .Ram_MemWrite(Ram_MemWrite),
    .Ram_WriteData(Ram_WriteData), .Ram_ReadData(Ram_ReadData)
  );

  always @(posedge Clock) if (Ram_MemWrite) ram[Ram_Address] <= Ram_WriteData;
  assign Ram_ReadData = ram[Ram_Address];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic bit bad_addr(input logic [31:0] a);
    return (a >= 32'h0001_0000) || (a[1:0] != 2'b00);
  endfunction

  function automatic exp_t predict(input bit w, input logic [31:0] a, input logic [31:0] d);
    exp_t e;
    e.w   = w;
    e.err = bad_addr(a);
    e.rd  = '0;
    if (w && !e.err) model[int'(a[15:2])] = d;
    if (!w && !e.err) e.rd = model[int'(a[15:2])];
    return e;
  endfunction

  always @(negedge Clock) begin
    exp_t e;
    cyc++;
    if (Ram_MemWrite) begin
      wr_pulses++;
      wr_addr_seen = Ram_Address;
    end
    if (M0_Ack) begin
      ack_port.push_back(0);
      ack_cyc.push_back(cyc);
      if (q0.size() == 0) check("m0_unexpected_ack", 1, 0);
      else begin
        e = q0.pop_front();
        $display("M0 ack w=%0d err=%0d rdata=%h", e.w, M0_Err, M0_ReadData);
        check("m0_err", M0_Err, e.err);
        if (!e.w) check("m0_rdata", M0_ReadData, e.rd);
      end
    end else if (M0_Err) check("m0_err_without_ack", 1, 0);
    if (M1_Ack) begin
      ack_port.push_back(1);
      ack_cyc.push_back(cyc);
      if (q1.size() == 0) check("m1_unexpected_ack", 1, 0);
      else begin
        e = q1.pop_front();
        $display("M1 ack w=%0d err=%0d rdata=%h", e.w, M1_Err, M1_ReadData);
        check("m1_err", M1_Err, e.err);
        if (!e.w) check("m1_rdata", M1_ReadData, e.rd);
      end
    end else if (M1_Err) check("m1_err_without_ack", 1, 0);
  end

  task automatic access(input int p, input bit w, input logic [31:0] a,
                        input logic [31:0] d, output int lat);
    logic ack;
    @(negedge Clock);
    if (p == 0) begin
      M0_Write = w; M0_Address = a; M0_WriteData = d; M0_Req = 1'b1;
      q0.push_back(predict(w, a, d));
    end else begin
      M1_Write = w; M1_Address = a; M1_WriteData = d; M1_Req = 1'b1;
      q1.push_back(predict(w, a, d));
    end
    lat = 0;
    do begin
      @(negedge Clock);
      lat++;
      ack = (p == 0) ? M0_Ack : M1_Ack;
    end while (!ack && lat < 40);
    if (!ack) check("ack_timeout", 0, 1);
    if (p == 0) M0_Req = 1'b0; else M1_Req = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_acks"}, {M0_Ack, M1_Ack, M0_Err, M1_Err, Ram_MemWrite}, 5'b0);
    check({tag, "_m0_rdata"}, M0_ReadData, 32'h0);
    check({tag, "_m1_rdata"}, M1_ReadData, 32'h0);
    check({tag, "_ram_addr"}, Ram_Address, 14'h0);
    check({tag, "_ram_wdata"}, Ram_WriteData, 32'h0);
  endtask

  initial begin
    int lat;
    int pulses0;
    Reset = 1'b1;
    M0_Req = 0; M0_Write = 0; M0_Address = 0; M0_WriteData = 0;
    M1_Req = 0; M1_Write = 0; M1_Address = 0; M1_WriteData = 0;
    repeat (2) @(negedge Clock);
    Reset = 1'b0;
    check_reset_outputs("reset");

    // M0 write then read
    pulses0 = wr_pulses;
    access(0, 1, 32'h40, 32'hDEAD_BEEF, lat);
    check("wr_pulse_count", wr_pulses - pulses0, 1);
    check("wr_ram_addr", wr_addr_seen, 14'h10);
    access(0, 0, 32'h40, 0, lat);
    check("rd_latency", lat, 2);

    // Background contents for later tests
    access(0, 1, 32'h0, 32'h1111_1111, lat);
    access(0, 1, 32'h80, 32'hA5A5_A5A5, lat);
    access(1, 1, 32'h44, 32'hCAFE_F00D, lat);
    access(1, 0, 32'h44, 0, lat);

    // Rejected write lands on word 0 if the range check were missing
    pulses0 = wr_pulses;
    access(1, 1, 32'h0001_0000, 32'hBAD0_BAD0, lat);
    check("rej_no_memwrite", wr_pulses - pulses0, 0);
    check("rej_ram_word0", ram[0], 32'h1111_1111);
    access(0, 0, 32'h0, 0, lat);

    // Misaligned read
    access(0, 0, 32'h42, 0, lat);
    check("misal_m0_rdata", M0_ReadData, 32'h0);
    check("misal_m1_keeps", M1_ReadData, 32'hCAFE_F00D);

    // Reset during ACCESS of a write
    @(negedge Clock);
    M0_Write = 1; M0_Address = 32'h80; M0_WriteData = 32'h1234_5678; M0_Req = 1;
    @(posedge Clock); #1;
    check("midrst_memwrite_on", Ram_MemWrite, 1);
    check("midrst_addr", Ram_Address, 14'h20);
    #1 Reset = 1'b1;
    #1;
    check("midrst_memwrite_off", Ram_MemWrite, 0);
    check_reset_outputs("midrst");
    M0_Req = 1'b0;
    @(posedge Clock); #1;
    check("midrst_ram_unchanged", ram[14'h20], 32'hA5A5_A5A5);
    @(negedge Clock);
    Reset = 1'b0;
    check_reset_outputs("midrst_release");

    // Simultaneous requests straight after reset: M0 first, then alternate
    ack_port.delete();
    ack_cyc.delete();
    M0_Write = 0; M0_Address = 32'h40;
    M1_Write = 0; M1_Address = 32'h44;
    q0.push_back(predict(0, 32'h40, 0));
    q1.push_back(predict(0, 32'h44, 0));
    q0.push_back(predict(0, 32'h40, 0));
    q1.push_back(predict(0, 32'h44, 0));
    M0_Req = 1; M1_Req = 1;
    repeat (12) @(negedge Clock);
    M0_Req = 0; M1_Req = 0;
    check("tie_ack_count", ack_port.size(), 4);
    if (ack_port.size() == 4) begin
      check("tie_order", {ack_port[0][1:0], ack_port[1][1:0], ack_port[2][1:0], ack_port[3][1:0]},
            8'b00_01_00_01);
      check("tie_m1_gap", ack_cyc[1] - ack_cyc[0], 3);
      check("tie_m0_gap", ack_cyc[2] - ack_cyc[0], 6);
    end
    access(0, 0, 32'h80, 0, lat);
    check("post_rst_latency", lat, 2);

    // Loader fills 16 words, CPU reads them back
    for (int i = 0; i < 16; i++) access(1, 1, 32'h200 + 32'(i * 4), $urandom, lat);
    for (int i = 0; i < 16; i++) access(0, 0, 32'h200 + 32'(i * 4), 0, lat);

    repeat (3) @(negedge Clock);
    check("q0_drained", q0.size(), 0);
    check("q1_drained", q1.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
